inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Decoupling FIFO between the last fetch stage (IF3) and decode.
- Accepts up to two fetched instructions per cycle, each with PC and next-line-predictor info, and presents up to two per cycle to decode.
- Enforces MIPS branch/delay-slot pairing at the output so decode always sees a branch together with its delay slot.
- Raises a pause request toward the fetch control when it cannot accept a full pair.

Parameters:
- DEPTH, 16, number of instruction entries; power of two, ≥4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all contents (from Ctrl)
- pause_req  out  1  fetch must hold; equals ~in_ready
- in_valid0  in  1  lane-0 instruction valid
- in_valid1  in  1  lane-1 instruction valid; only legal with in_valid0=1
- in_pc0, in_pc1  in  32  instruction PCs
- in_inst0, in_inst1  in  32  instruction words
- in_is_br0, in_is_br1  in  1  pre-decoded branch/jump flag
- in_taken0, in_taken1  in  1  NLP predicted taken
- in_target0, in_target1  in  32  NLP predicted target
- in_ready  out  1  queue has ≥2 free entries
- out_valid0, out_valid1  out  1  decode-lane valids
- out_pc0/1, out_inst0/1, out_is_br0/1, out_taken0/1, out_target0/1  out  32/32/1/1/32  head and head+1 entry fields
- out_ack0, out_ack1  in  1  decode consumes lane 0 / lanes 0 and 1; out_ack1 only with out_ack0

Behaviour:
- Storage: circular buffer, DEPTH entries of 98 bits (pc, inst, is_br, taken, target). Pointers head and tail are log2(DEPTH)+1 bits wide; the extra MSB disambiguates full from empty. count = tail − head, modulo 2^(log2(DEPTH)+1).
- Reset or flush: head=tail=0 on the next edge. Stored data is not cleared. Outputs after the edge: out_valid0/1=0, in_ready=1, pause_req=0.
- Flush beats everything: enqueue and dequeue in the flush cycle are both dropped.
- Enqueue: happens when in_ready && in_valid0.
  - Lane 0 is written at tail, lane 1 at tail+1 (with wrap-around).
  - tail advances by 1 or 2.
  - Order is preserved: lane 0 is older.
  - in_valid0/1 while in_ready=0 are ignored. Upstream holds them because pause_req=1.
- in_ready = (DEPTH − count ≥ 2). Combinational from registered pointers, so it does not depend on the current cycle's dequeue.
- Output lanes: lane 0 shows entry[head], lane 1 shows entry[head+1]. Both are combinational reads.
  - Raw valids: v0 = count≥1, v1 = count≥2.
  - out_valid0 = v0 && !(is_br[head] && !v1). A branch at the head is withheld until its delay slot is in the queue.
  - out_valid1 = v1 && !is_br[head+1]. A branch in lane 1 is deferred so it reaches lane 0 next cycle paired with its delay slot.
  - If lane 0 is a branch and v1=1, out_valid1=1 (the delay slot), even if that entry is itself a branch.
- Dequeue: head advances by out_ack0 + out_ack1.
  - Acks must not exceed the corresponding out_valid; the bench checks this with an assertion.
  - If decode acks lane 0 holding a branch, it must also ack lane 1. The assertion fires otherwise.
- Simultaneous enqueue and dequeue in the same cycle are both applied. count updates by (enqueued − dequeued).
- Latency: an entry written at edge N is visible on out_* after edge N (one-cycle fall-through, no bypass).
- Pointer wrap: low bits index the array; the MSB toggles on each pass.
- Reset mid-operation is treated identically to flush.

Test Plan:
- Reset, then enqueue pairs (PC 0x100/0x104, 0x108/0x10C) with no acks → after 2 edges count=4, out_pc0=0x100, out_pc1=0x104, both valid.
- Fill to DEPTH−1 with single enqueues, no acks → in_ready=0 and pause_req=1 at count 15. A further in_valid0 leaves count=15. One ack → in_ready=1 next cycle.
- Branch at head with no following entry (PC 0x200, is_br=1, count=1) → out_valid0=0. Enqueue DS 0x204 → next cycle out_valid0=out_valid1=1, pcs 0x200/0x204.
- Non-branch at head 0x300, branch 0x304 in lane 1 → out_valid1=0. Ack lane 0 → 0x304 moves to lane 0. Once 0x308 is present, both lanes are valid.
- Continuous enqueue-2/ack-2 for 40 cycles across pointer wrap → output PC sequence strictly increments by 4 with no gaps or duplicates.
- Flush asserted in the same cycle as enqueue and ack at count=6 → next cycle count=0, out_valid0=0, in_ready=1. The enqueued pair is absent.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Decoupling FIFO between the last fetch stage (IF3) and decode. Accepts up
//   to two instructions per cycle and presents up to two per cycle, holding a
//   branch back until its delay slot is also present so that decode always
//   receives the branch and its delay slot together.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             discard all contents (wins over enqueue/dequeue)
//   pause_req         fetch must hold (~in_ready)
//   in_valid0/1       fetch lane valids (lane 1 only with lane 0)
//   in_pc/inst/is_br/taken/target 0/1   fetched instruction fields
//   in_ready          at least two free entries
//   out_valid0/1      decode lane valids
//   out_pc/inst/is_br/taken/target 0/1  entries at head and head+1
//   out_ack0/1        decode consumes lane 0 / lanes 0 and 1
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    output logic        pause_req,

    input  logic        in_valid0,
    input  logic        in_valid1,
    input  logic [31:0] in_pc0,
    input  logic [31:0] in_pc1,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    input  logic        in_is_br0,
    input  logic        in_is_br1,
    input  logic        in_taken0,
    input  logic        in_taken1,
    input  logic [31:0] in_target0,
    input  logic [31:0] in_target1,
    output logic        in_ready,

    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic        out_is_br0,
    output logic        out_is_br1,
    output logic        out_taken0,
    output logic        out_taken1,
    output logic [31:0] out_target0,
    output logic [31:0] out_target1,
    input  logic        out_ack0,
    input  logic        out_ack1
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] READY_MAX = PW'(DEPTH - 2);

    logic [31:0] mem_pc     [DEPTH];
    logic [31:0] mem_inst   [DEPTH];
    logic        mem_br     [DEPTH];
    logic        mem_taken  [DEPTH];
    logic [31:0] mem_target [DEPTH];

    // Extra MSB on the pointers distinguishes full from empty.
    logic [PW-1:0] head, tail, head_p1, tail_p1, count;
    logic [PW-1:0] enq_n, deq_n;
    logic [AW-1:0] hidx0, hidx1, tidx0, tidx1;
    logic          enq, raw_v0, raw_v1;

    always_comb begin
        count     = tail - head;
        head_p1   = head + PW'(1);
        tail_p1   = tail + PW'(1);
        hidx0     = head[AW-1:0];
        hidx1     = head_p1[AW-1:0];
        tidx0     = tail[AW-1:0];
        tidx1     = tail_p1[AW-1:0];
        in_ready  = (count <= READY_MAX);
        pause_req = ~in_ready;
        enq       = in_ready && in_valid0;
        enq_n     = in_valid1 ? PW'(2) : PW'(1);
        deq_n     = PW'(out_ack0) + PW'(out_ack1);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq) begin
                tail <= tail + enq_n;
            end
            head <= head + deq_n;
        end
    end

    // Payload storage is never cleared; pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (!rst && !flush && enq) begin
            mem_pc[tidx0]     <= in_pc0;
            mem_inst[tidx0]   <= in_inst0;
            mem_br[tidx0]     <= in_is_br0;
            mem_taken[tidx0]  <= in_taken0;
            mem_target[tidx0] <= in_target0;
            if (in_valid1) begin
                mem_pc[tidx1]     <= in_pc1;
                mem_inst[tidx1]   <= in_inst1;
                mem_br[tidx1]     <= in_is_br1;
                mem_taken[tidx1]  <= in_taken1;
                mem_target[tidx1] <= in_target1;
            end
        end
    end

    always_comb begin
        out_pc0     = mem_pc[hidx0];
        out_inst0   = mem_inst[hidx0];
        out_is_br0  = mem_br[hidx0];
        out_taken0  = mem_taken[hidx0];
        out_target0 = mem_target[hidx0];
        out_pc1     = mem_pc[hidx1];
        out_inst1   = mem_inst[hidx1];
        out_is_br1  = mem_br[hidx1];
        out_taken1  = mem_taken[hidx1];
        out_target1 = mem_target[hidx1];

        raw_v0 = (count != '0);
        raw_v1 = (count >= PW'(2));
        // Head branch waits for its delay slot; a lane-1 branch is deferred
        // unless it is itself the delay slot of a head branch.
        out_valid0 = raw_v0 && !(out_is_br0 && !raw_v1);
        out_valid1 = raw_v1 && (out_is_br0 || !out_is_br1);
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, flush, pause_req;
    logic        in_valid0, in_valid1, in_is_br0, in_is_br1, in_taken0, in_taken1;
    logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1, in_target0, in_target1;
    logic        in_ready;
    logic        out_valid0, out_valid1, out_is_br0, out_is_br1, out_taken0, out_taken1;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1, out_target0, out_target1;
    logic        out_ack0, out_ack1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pause_req(pause_req),
        .in_valid0(in_valid0), .in_valid1(in_valid1),
        .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
        .in_is_br0(in_is_br0), .in_is_br1(in_is_br1),
        .in_taken0(in_taken0), .in_taken1(in_taken1),
        .in_target0(in_target0), .in_target1(in_target1),
        .in_ready(in_ready),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_is_br0(out_is_br0), .out_is_br1(out_is_br1),
        .out_taken0(out_taken0), .out_taken1(out_taken1),
        .out_target0(out_target0), .out_target1(out_target1),
        .out_ack0(out_ack0), .out_ack1(out_ack1)
    );

    always #5 clk = ~clk;

    // Reference queue: plain FIFO of entries following the enqueue/dequeue rules.
    always @(posedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            bit can_take;
            can_take = (DEPTH - q.size() >= 2);
            if (out_ack0 && q.size() > 0) void'(q.pop_front());
            if (out_ack1 && q.size() > 0) void'(q.pop_front());
            if (can_take && in_valid0) begin
                q.push_back('{in_pc0, in_inst0, in_is_br0, in_taken0, in_target0});
                if (in_valid1)
                    q.push_back('{in_pc1, in_inst1, in_is_br1, in_taken1, in_target1});
            end
        end
    end

    a_ack0_legal: assert property (@(posedge clk) disable iff (rst) out_ack0 |-> out_valid0);
    a_ack1_legal: assert property (@(posedge clk) disable iff (rst) out_ack1 |-> (out_ack0 && out_valid1));
    a_br_pair:    assert property (@(posedge clk) disable iff (rst) (out_ack0 && out_is_br0) |-> out_ack1);

    task automatic idle();
        rst = 0; flush = 0; in_valid0 = 0; in_valid1 = 0;
        in_is_br0 = 0; in_is_br1 = 0; out_ack0 = 0; out_ack1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic v0, input logic v1, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic b0, input logic b1);
        in_valid0 = v0; in_valid1 = v1;
        in_pc0 = pc0; in_pc1 = pc1; in_is_br0 = b0; in_is_br1 = b1;
        in_inst0 = $urandom; in_inst1 = $urandom;
        in_taken0 = 1'($urandom_range(0, 1)); in_taken1 = 1'($urandom_range(0, 1));
        in_target0 = $urandom; in_target1 = $urandom;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        put(1, 1, 32'h40, 32'h44, 0, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_v0 got %b want 0", out_valid0); end
        n_cmp++; if (out_valid1 !== 1'b0) begin n_bad++; $display("FAIL reset_v1 got %b want 0", out_valid1); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL reset_pause got %b want 0", pause_req); end
    endtask

    task automatic test_pairs();
        logic [31:0] inst_a;
        do_reset();
        put(1, 1, 32'h100, 32'h104, 0, 0);
        inst_a = in_inst0;
        tick();
        n_cmp++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h100) begin
            n_bad++; $display("FAIL pair_latency got v0=%b pc0=%h want 1/100", out_valid0, out_pc0); end
        put(1, 1, 32'h108, 32'h10C, 0, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b1) begin n_bad++; $display("FAIL pair_v0 got %b want 1", out_valid0); end
        n_cmp++; if (out_valid1 !== 1'b1) begin n_bad++; $display("FAIL pair_v1 got %b want 1", out_valid1); end
        n_cmp++; if (out_pc0 !== 32'h100) begin n_bad++; $display("FAIL pair_pc0 got %h want 100", out_pc0); end
        n_cmp++; if (out_pc1 !== 32'h104) begin n_bad++; $display("FAIL pair_pc1 got %h want 104", out_pc1); end
        n_cmp++; if (out_inst0 !== inst_a) begin n_bad++; $display("FAIL pair_inst0 got %h want %h", out_inst0, inst_a); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pair_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fill();
        logic [31:0] exp_pc;
        int drained;
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got %b want 1", i, in_ready); end
            put(1, 0, 32'h400 + 32'(4 * i), 32'h0, 0, 0);
            tick();
        end
        idle();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", in_ready); end
        n_cmp++; if (pause_req !== 1'b1) begin n_bad++; $display("FAIL full_pause got %b want 1", pause_req); end
        put(1, 0, 32'h500, 32'h0, 0, 0);
        tick();
        idle();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold got %b want 0", in_ready); end
        out_ack0 = 1;
        tick();
        idle();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL unfull_ready got %b want 1", in_ready); end
        exp_pc = 32'h404;
        drained = 0;
        for (int k = 0; k < 20 && out_valid0 === 1'b1; k++) begin
            n_cmp++; if (out_pc0 !== exp_pc) begin n_bad++; $display("FAIL drain_pc0 got %h want %h", out_pc0, exp_pc); end
            out_ack0 = 1;
            out_ack1 = out_valid1;
            drained += out_valid1 ? 2 : 1;
            exp_pc += out_valid1 ? 32'd8 : 32'd4;
            tick();
            idle();
        end
        n_cmp++; if (drained != 14) begin n_bad++; $display("FAIL drain_count got %0d want 14", drained); end
    endtask

    task automatic test_branch_head();
        do_reset();
        put(1, 0, 32'h200, 32'h0, 1, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL brhead_wait got %b want 0", out_valid0); end
        put(1, 0, 32'h204, 32'h0, 0, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin
            n_bad++; $display("FAIL brhead_pair got v0=%b v1=%b want 1/1", out_valid0, out_valid1); end
        n_cmp++; if (out_pc0 !== 32'h200 || out_pc1 !== 32'h204) begin
            n_bad++; $display("FAIL brhead_pcs got %h/%h want 200/204", out_pc0, out_pc1); end
        out_ack0 = 1; out_ack1 = 1;
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL brhead_empty got %b want 0", out_valid0); end
    endtask

    task automatic test_branch_lane1();
        do_reset();
        put(1, 1, 32'h300, 32'h304, 0, 1);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL brl1_defer got v0=%b v1=%b want 1/0", out_valid0, out_valid1); end
        out_ack0 = 1;
        tick();
        idle();
        n_cmp++; if (out_pc0 !== 32'h304 || out_valid0 !== 1'b0) begin
            n_bad++; $display("FAIL brl1_move got pc0=%h v0=%b want 304/0", out_pc0, out_valid0); end
        put(1, 0, 32'h308, 32'h0, 0, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || out_pc1 !== 32'h308) begin
            n_bad++; $display("FAIL brl1_pair got v0=%b v1=%b pc1=%h want 1/1/308", out_valid0, out_valid1, out_pc1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, exp_pc;
        int acked;
        do_reset();
        pc = 32'h1000;
        exp_pc = 32'h1000;
        acked = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid0 === 1'b1 && out_valid1 === 1'b1) begin
                n_cmp++; if (out_pc0 !== exp_pc || out_pc1 !== exp_pc + 32'd4) begin
                    n_bad++; $display("FAIL b2b_seq got %h/%h want %h/%h", out_pc0, out_pc1, exp_pc, exp_pc + 32'd4); end
                out_ack0 = 1; out_ack1 = 1;
                exp_pc += 32'd8;
                acked += 2;
            end else begin
                out_ack0 = 0; out_ack1 = 0;
            end
            put(1, 1, pc, pc + 32'd4, 0, 0);
            pc += 32'd8;
            tick();
        end
        idle();
        n_cmp++; if (acked != 78) begin n_bad++; $display("FAIL b2b_count got %0d want 78", acked); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            put(1, 1, 32'h600 + 32'(8 * i), 32'h604 + 32'(8 * i), 0, 0);
            tick();
        end
        put(1, 1, 32'h680, 32'h684, 0, 0);
        out_ack0 = 1; out_ack1 = 1;
        flush = 1;
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL flush_valid got %b/%b want 0/0", out_valid0, out_valid1); end
        n_cmp++; if (in_ready !== 1'b1 || pause_req !== 1'b0) begin
            n_bad++; $display("FAIL flush_ready got %b/%b want 1/0", in_ready, pause_req); end
        put(1, 0, 32'h700, 32'h0, 0, 0);
        tick();
        idle();
        n_cmp++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h700 || out_valid1 !== 1'b0) begin
            n_bad++; $display("FAIL flush_after got v0=%b pc0=%h v1=%b want 1/700/0", out_valid0, out_pc0, out_valid1); end
    endtask

    task automatic test_random();
        ent_t e0, e1;
        logic ev0, ev1, a0, a1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            e0 = (q.size() > 0) ? q[0] : '0;
            e1 = (q.size() > 1) ? q[1] : '0;
            ev0 = (q.size() >= 1) && !(e0.br && q.size() < 2);
            ev1 = (q.size() >= 2) && (e0.br || !e1.br);
            n_cmp++; if (in_ready !== (DEPTH - q.size() >= 2)) begin
                n_bad++; $display("FAIL rnd_ready c=%0d got %b size=%0d", c, in_ready, q.size()); end
            n_cmp++; if (pause_req !== !(DEPTH - q.size() >= 2)) begin
                n_bad++; $display("FAIL rnd_pause c=%0d got %b size=%0d", c, pause_req, q.size()); end
            n_cmp++; if (out_valid0 !== ev0 || out_valid1 !== ev1) begin
                n_bad++; $display("FAIL rnd_valid c=%0d got %b/%b want %b/%b", c, out_valid0, out_valid1, ev0, ev1); end
            if (q.size() >= 1) begin
                n_cmp++; if ({out_pc0, out_inst0, out_is_br0, out_taken0, out_target0} !== e0) begin
                    n_bad++; $display("FAIL rnd_lane0 c=%0d got %h want %h", c,
                        {out_pc0, out_inst0, out_is_br0, out_taken0, out_target0}, e0); end
            end
            if (q.size() >= 2) begin
                n_cmp++; if ({out_pc1, out_inst1, out_is_br1, out_taken1, out_target1} !== e1) begin
                    n_bad++; $display("FAIL rnd_lane1 c=%0d got %h want %h", c,
                        {out_pc1, out_inst1, out_is_br1, out_taken1, out_target1}, e1); end
            end
            a0 = ev0 && ($urandom_range(0, 9) < 5);
            a1 = a0 && ev1 && (e0.br || $urandom_range(0, 1) == 1);
            out_ack0 = a0; out_ack1 = a1;
            begin
                logic v0, v1;
                v0 = ($urandom_range(0, 9) < 7);
                v1 = v0 && ($urandom_range(0, 1) == 1);
                put(v0, v1, $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            end
            flush = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
        in_taken0 = 0; in_taken1 = 0; in_target0 = '0; in_target1 = '0;
        @(negedge clk);
        test_reset();
        test_pairs();
        test_fill();
        test_branch_head();
        test_branch_lane1();
        test_back_to_back();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
